// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed FFT output frames into natural order.
// Two ping-pong banks let one frame fill while the other drains.
module fft_output_reorder #(
  parameter int width = 16,
  parameter int log2n = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] re_in,
  input  logic [width-1:0] im_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] re_out,
  output logic [width-1:0] im_out,
  output logic             out_last
);

  localparam int n = 1 << log2n;
  localparam logic [log2n-1:0] last_idx = '1;
  localparam logic [log2n-1:0] cnt_one = 1;

  logic [2*width-1:0] mem [2*n];

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [log2n-1:0] wr_cnt;
  logic [log2n-1:0] rd_cnt;
  logic [log2n-1:0] wr_addr;
  logic             accept;
  logic             load;
  logic             wr_wrap;
  logic             rd_wrap;
  logic [2*width-1:0] rd_word;

  function automatic logic [log2n-1:0] bitrev(
    input logic [log2n-1:0] a
  );
    logic [log2n-1:0] r;
    r = '0;
    for (int i = 0; i < log2n; i++)
      r[i] = a[log2n-1-i];
    return r;
  endfunction

  assign in_ready = ~full[wr_bank];
  assign accept   = in_valid & in_ready;
  assign load     = (~out_valid | out_ready)
                  & full[rd_bank];
  assign wr_wrap  = (wr_cnt == last_idx);
  assign rd_wrap  = (rd_cnt == last_idx);
  assign wr_addr  = bitrev(wr_cnt);
  assign rd_word  = mem[{rd_bank, rd_cnt}];

  // Scatter each incoming sample to its natural-order slot.
  always_ff @(posedge clock) begin
    if (accept)
      mem[{wr_bank, wr_addr}] <= {re_in, im_in};
  end

  // Fill completes one bank while drain may free the other.
  always_comb begin
    full_nxt = full;
    if (accept && wr_wrap)
      full_nxt[wr_bank] = 1'b1;
    if (load && rd_wrap)
      full_nxt[rd_bank] = 1'b0;
  end

  // Write side: counter and bank pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + cnt_one;
      if (wr_wrap)
        wr_bank <= ~wr_bank;
    end
  end

  // Bank full flags.
  always_ff @(posedge clock) begin
    if (reset)
      full <= '0;
    else
      full <= full_nxt;
  end

  // Read side: counter and bank pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (load) begin
      rd_cnt <= rd_cnt + cnt_one;
      if (rd_wrap)
        rd_bank <= ~rd_bank;
    end
  end

  // Output register: load, hold under backpressure, or empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      re_out    <= '0;
      im_out    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= rd_wrap;
      re_out    <= rd_word[2*width-1:width];
      im_out    <= rd_word[width-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder (N=16).
// Stimulus pushes expected natural-order frames; monitor pops.
module tb_fft_output_reorder;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] re_in = '0;
  logic [W-1:0] im_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] re_out;
  logic [W-1:0] im_out;
  logic         out_last;

  fft_output_reorder #(.width(W), .log2n(L)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .re_in    (re_in),
    .im_in    (im_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .re_out   (re_out),
    .im_out   (im_out),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        lst;
  } exp_t;

  int   passes = 0;
  int   total = 0;
  int   cyc = 0;
  int   mode = 0;
  bit   track = 1'b0;
  int   pop_cyc[$];
  exp_t q[$];
  int   perm[16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                     1, 9, 5, 13, 3, 11, 7, 15};
  logic [15:0] fre[16];
  logic [15:0] fim[16];
  int   fcnt = 0;
  logic hold_pend = 1'b0;
  logic [15:0] hre, him;
  logic hlast;

  always @(posedge clock) cyc++;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic record(logic [15:0] re, logic [15:0] im);
    exp_t e;
    fre[fcnt] = re;
    fim[fcnt] = im;
    fcnt++;
    if (fcnt == N) begin
      for (int k = 0; k < N; k++) begin
        e.re  = fre[perm[k]];
        e.im  = fim[perm[k]];
        e.lst = (k == N - 1);
        q.push_back(e);
      end
      fcnt = 0;
    end
  endtask

  // out_ready pattern per test phase.
  always @(posedge clock) begin
    #1;
    case (mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: hold check and scoreboard pop.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_re", re_out, hre);
        chk("hold_im", im_out, him);
        chk("hold_last", out_last, hlast);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("out_re", re_out, e.re);
          chk("out_im", im_out, e.im);
          chk("out_last", out_last, e.lst);
          if (track) pop_cyc.push_back(cyc);
        end
      end
      hold_pend = out_valid && !out_ready;
      hre = re_out;
      him = im_out;
      hlast = out_last;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(logic [15:0] re, logic [15:0] im,
                      output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    in_valid = 1'b1;
    re_in = re;
    im_in = im;
    forever begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      if (ok) break;
      stalls++;
      if (stalls > 300) begin
        chk("send_timeout", in_ready, 1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    if (ok) record(re, im);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 600) begin
      idle(1);
      t++;
    end
    chk("drain", q.size(), 0);
    idle(3);
  endtask

  initial begin
    int st;
    int stalls;
    int acc0;
    int acc;
    bit ok;

    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_re_out", re_out, 0);
    chk("rst_im_out", im_out, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clock);
    #1;

    // Basic frame: re=i, im=-i.
    mode = 1;
    for (int i = 0; i < N; i++)
      send(16'(i), 16'(-i), st);
    drain();

    // Input gaps: one sample every third cycle.
    for (int i = 0; i < N; i++) begin
      idle(1);
      if (i == N - 1) begin
        @(negedge clock);
        chk("gap_no_early", out_valid, 0);
        @(posedge clock);
        #1;
      end else begin
        idle(1);
      end
      send(16'h0100 + 16'(i), 16'hA000 + 16'(i), st);
    end
    drain();

    // Three back-to-back frames.
    track = 1'b1;
    pop_cyc.delete();
    stalls = 0;
    acc0 = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        send(16'h0200 + 16'(f * 16 + i),
             16'h7000 - 16'(f * 16 + i), st);
        stalls += st;
        if (f == 0 && i == N - 1) acc0 = cyc;
      end
    drain();
    track = 1'b0;
    chk("burst_stalls", stalls, 0);
    chk("burst_count", pop_cyc.size(), 48);
    if (pop_cyc.size() == 48) begin
      chk("burst_contig", pop_cyc[47] - pop_cyc[0], 47);
      chk("burst_latency", pop_cyc[0] - acc0, 1);
    end

    // Random backpressure during readout.
    mode = 2;
    for (int i = 0; i < N; i++)
      send(16'h0300 + 16'(i), 16'h5500 ^ 16'(i), st);
    drain();
    mode = 1;
    idle(2);

    // No readout: both banks fill, input stalls.
    mode = 0;
    idle(1);
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      re_in = 16'(c);
      im_in = 16'(-c);
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      if (ok) begin
        record(16'(c), 16'(-c));
        acc++;
      end
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("stall_accepts", acc, 32);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_re0", re_out, 0);
    chk("stall_im0", im_out, 0);
    chk("stall_last", out_last, 0);
    @(posedge clock);
    #1;
    mode = 1;
    drain();

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++)
      send(16'h0400 + 16'(i), 16'h0480 + 16'(i), st);
    reset = 1'b1;
    fcnt = 0;
    idle(1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    @(posedge clock);
    #1;
    idle(30);
    chk("mid_rst_no_out", out_valid, 0);
    for (int i = 0; i < N; i++)
      send(16'h0500 + 16'(i), 16'h0600 + 16'(i), st);
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
